// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding, parity mode constants and frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_CLEANUP
  } rx_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // Total bit periods in one frame, start bit included.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity_mode,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus optional 2-of-3 sample filter.
// Filter enabled by defining UART_RX_MAJORITY_VOTE_EN; otherwise the bit value is the synchronized sample.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_Rx_Serial,
  output logic o_Rx_Sync,
  output logic o_Rx_Bit
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_Rx_Serial;
      r_sync <= r_meta;
    end
  end

  assign o_Rx_Sync = r_sync;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // History of the two previous synchronized samples, so the vote covers points -2, -1 and 0.
  logic r_hist1;
  logic r_hist2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hist1 <= 1'b1;
      r_hist2 <= 1'b1;
    end else begin
      r_hist1 <= r_sync;
      r_hist2 <= r_hist1;
    end
  end

  assign o_Rx_Bit = (r_sync & r_hist1) | (r_sync & r_hist2) | (r_hist1 & r_hist2);
`else
  assign o_Rx_Bit = r_sync;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with output holding register, parity/frame error flags and overrun pulse.
// Optional majority-vote bit sampling via UART_RX_MAJORITY_VOTE_EN (handled in uart_rx_sync).
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_CY_PER_BIT = 87,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned PARITY_MODE    = 1,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_Rx_Serial,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Rx_Dv,
  input  logic                 i_Rx_Ready,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic                 o_Busy
);

  localparam int unsigned CNT_W = $clog2(CLK_CY_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_CY_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'((CLK_CY_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  logic w_rx_sync;
  logic w_rx_bit;

  uart_rx_sync u_sync (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_Rx_Serial (i_Rx_Serial),
    .o_Rx_Sync   (w_rx_sync),
    .o_Rx_Bit    (w_rx_bit)
  );

  rx_state_t            r_state,  w_state_nxt;
  logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx,    w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift,  w_shift_nxt;
  logic                 r_perr,   w_perr_nxt;
  logic                 r_ferr,   w_ferr_nxt;
  logic                 r_break,  w_break_nxt;
  logic [DATA_BITS-1:0] r_Rx_Byte,    w_byte_nxt;
  logic                 r_Rx_Dv,      w_dv_nxt;
  logic                 r_Parity_Err, w_perr_out_nxt;
  logic                 r_Frame_Err,  w_ferr_out_nxt;
  logic                 r_Overrun,    w_ovr_nxt;
  logic                 w_cnt_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_break      <= 1'b0;
      r_Rx_Byte    <= '0;
      r_Rx_Dv      <= 1'b0;
      r_Parity_Err <= 1'b0;
      r_Frame_Err  <= 1'b0;
      r_Overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_perr       <= w_perr_nxt;
      r_ferr       <= w_ferr_nxt;
      r_break      <= w_break_nxt;
      r_Rx_Byte    <= w_byte_nxt;
      r_Rx_Dv      <= w_dv_nxt;
      r_Parity_Err <= w_perr_out_nxt;
      r_Frame_Err  <= w_ferr_out_nxt;
      r_Overrun    <= w_ovr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_shift_nxt    = r_shift;
    w_perr_nxt     = r_perr;
    w_ferr_nxt     = r_ferr;
    w_break_nxt    = r_break;
    w_byte_nxt     = r_Rx_Byte;
    w_dv_nxt       = r_Rx_Dv;
    w_perr_out_nxt = r_Parity_Err;
    w_ferr_out_nxt = r_Frame_Err;
    w_ovr_nxt      = 1'b0;
    w_cnt_last     = (r_cnt == CNT_LAST);

    if (r_Rx_Dv && i_Rx_Ready) w_dv_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt  = '0;
        w_idx_nxt  = '0;
        w_perr_nxt = 1'b0;
        w_ferr_nxt = 1'b0;
        // After a frame error the line must be seen high before a new start is accepted.
        if (w_rx_sync)     w_break_nxt = 1'b0;
        else if (!r_break) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (r_cnt == CNT_MID) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx_bit ? ST_IDLE : ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_cnt_last) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = w_rx_bit;
          if (r_idx == DATA_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_PARITY: begin
        if (w_cnt_last) begin
          w_cnt_nxt   = '0;
          w_perr_nxt  = (^r_shift) ^ w_rx_bit ^ (PARITY_MODE == PARITY_ODD);
          w_state_nxt = ST_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (w_cnt_last) begin
          w_cnt_nxt = '0;
          if (!w_rx_bit) w_ferr_nxt = 1'b1;
          if (r_idx == STOP_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_CLEANUP;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_CLEANUP: begin
        if (!r_Rx_Dv || i_Rx_Ready) begin
          w_byte_nxt     = r_shift;
          w_perr_out_nxt = r_perr;
          w_ferr_out_nxt = r_ferr;
          w_dv_nxt       = 1'b1;
        end else begin
          w_ovr_nxt = 1'b1;
        end
        w_break_nxt = r_ferr;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_Rx_Byte    = r_Rx_Byte;
  assign o_Rx_Dv      = r_Rx_Dv;
  assign o_Parity_Err = r_Parity_Err;
  assign o_Frame_Err  = r_Frame_Err;
  assign o_Overrun    = r_Overrun;
  assign o_Busy       = (r_state != ST_IDLE);

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLK_CY_PER_BIT, default 87: i_clk cycles per serial bit, legal range 8..4095.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-003 SHALL have parameter PARITY_MODE, default 1: 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-005 SHALL have port i_clk, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port i_Rx_Serial, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port o_Rx_Byte, output, DATA_BITS wide: received data, LSB first on the line.
REQ-009 SHALL have port o_Rx_Dv, output, 1 bit: output holding register valid.
REQ-010 SHALL have port i_Rx_Ready, input, 1 bit: consumer accepts o_Rx_Byte when o_Rx_Dv and i_Rx_Ready are both high.
REQ-011 SHALL have port o_Parity_Err, output, 1 bit: parity error qualifier for the held frame.
REQ-012 SHALL have port o_Frame_Err, output, 1 bit: stop-bit error qualifier for the held frame.
REQ-013 SHALL have port o_Overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.
REQ-014 SHALL have port o_Busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL pass i_Rx_Serial through a 2-flop synchronizer before any use.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, CLEANUP.
REQ-017 SHALL move IDLE->START on a synchronized low, with the cycle counter cleared.
REQ-018 SHALL sample in START at count == (CLK_CY_PER_BIT-1)/2: low -> DATA with counter cleared; high -> IDLE (false start, no output).
REQ-019 SHALL sample each subsequent bit when the counter reaches CLK_CY_PER_BIT-1, then clear the counter.
REQ-020 SHALL shift DATA_BITS samples into bit index 0 upward, then go to PARITY if PARITY_MODE != 0, else to STOP.
REQ-021 SHALL flag a parity error when, for even parity, the XOR of data and parity bit is 1, and for odd parity, when it is 0.
REQ-022 SHALL sample STOP_BITS stop bits and flag a frame error if any stop sample is low.
REQ-023 SHALL, in CLEANUP (one cycle): if o_Rx_Dv is low or i_Rx_Ready is high that cycle, load o_Rx_Byte and both error flags and set o_Rx_Dv; otherwise drop the frame and pulse o_Overrun, leaving the held frame untouched; then go to IDLE.
REQ-024 SHALL clear o_Rx_Dv on the cycle after an accept, unless CLEANUP reloads it that same cycle.
REQ-025 SHALL hold o_Rx_Byte, o_Parity_Err and o_Frame_Err stable while o_Rx_Dv is high.
REQ-026 SHALL, after a frame error, return to IDLE and rearm only once the synchronized line is seen high (no back-to-back retrigger during a break).
REQ-027 SHALL size the counter to $clog2(CLK_CY_PER_BIT) bits, with no wrap before CLK_CY_PER_BIT-1.

Reset
REQ-028 SHALL, on i_rst high: state = IDLE, counter and bit index = 0, synchronizer flops = 1, o_Rx_Byte = 0, o_Rx_Dv, o_Parity_Err, o_Frame_Err and o_Overrun = 0.
REQ-029 SHALL, on reset mid-frame, discard the partial frame and restart detection only after deassertion plus a synchronized low.

Configuration
REQ-030 SHALL, with macro UART_RX_MAJORITY_VOTE_EN defined, take each bit value (including start) as the 2-of-3 majority of the synchronized samples at sample point -2, -1 and 0.
REQ-031 SHALL, without UART_RX_MAJORITY_VOTE_EN, use the single synchronized sample at the sample point; timing is identical in both builds.

Structure
REQ-032 SHALL place the FSM state encodings, the PARITY_MODE constants (PARITY_NONE/EVEN/ODD) and the frame-length helper function in shared package uart_pkg.
REQ-033 SHALL implement the synchronizer and majority filter as sub-module uart_rx_sync; the FSM, counters and holding register stay in uart_rx_param.

Verification (CLK_CY_PER_BIT=16, DATA_BITS=8, PARITY_MODE=1, STOP_BITS=1 unless noted)
REQ-034 SHALL cover: frame 0xA5 with parity 0 and stop 1, i_Rx_Ready=1 -> o_Rx_Byte=0xA5, o_Rx_Dv pulse, both error flags 0.
REQ-035 SHALL cover: frame 0x3C with parity bit 1 -> o_Rx_Byte=0x3C, o_Parity_Err=1.
REQ-036 SHALL cover: frame 0x55 with stop bit 0 -> o_Frame_Err=1; no new frame starts until the line returns high.
REQ-037 SHALL cover: 5-cycle low glitch on an idle line -> no o_Rx_Dv, o_Busy back to 0 within 10 cycles.
REQ-038 SHALL cover: frames 0x11 then 0x22 with i_Rx_Ready=0 -> o_Rx_Byte stays 0x11, o_Overrun pulses once.
REQ-039 SHALL cover: i_rst asserted mid-data of 0xFF, then frame 0x81 after release -> only 0x81 is delivered.
